// File: rtl/pipe_skid_stage_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage_pkg
//   Shared definitions for the pipeline stage registers (IF/ID, ID/EX,
//   EX/MEM, MEM/WB).
//   - FSM state encodings for the stage holding register.
//   - Default NOP control word, used as BUBBLE by the ID/EX instance.
//   - Helper that maps a stage state to its entry count.
// -----------------------------------------------------------------------------
package pipe_skid_stage_pkg;

   // Stage FSM encodings. The numeric value equals the number of held
   // entries, so occupancy can be derived directly from the state.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   // All-zero control word decodes as a NOP in the ID/EX control field:
   // no register write, no memory access, no branch.
   localparam logic [31:0] NOP_CTRL = 32'h0000_0000;

   // Number of entries held by the stage in a given state. Unused
   // encodings report zero, matching the recovery state of the FSM.
   function automatic logic [1:0] state_occupancy(input logic [1:0] st);
      logic [1:0] occ;
      case (st)
         ST_EMPTY: occ = 2'd0;
         ST_ONE:   occ = 2'd1;
         ST_TWO:   occ = 2'd2;
         default:  occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage_if
//   Handshake bundle around one pipeline stage register.
//   Upstream side : in_valid, in_data  (into the stage), in_ready (out of it)
//   Downstream    : out_valid, out_data (out of the stage), out_ready (into it)
//   Modports:
//     slave  - the stage itself
//     master - whatever surrounds the stage (producer + consumer)
// -----------------------------------------------------------------------------
interface pipe_skid_stage_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      output out_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      input  out_ready
   );

endinterface

// File: rtl/pipe_skid_stage_data_reg.sv
// -----------------------------------------------------------------------------
// pipe_data_reg
//   WIDTH-bit holding register with load enable and a synchronous clear to
//   RST_VAL. Clear wins over load.
//   Ports:
//     CLK   in   1      clock
//     clr   in   1      synchronous clear to RST_VAL
//     load  in   1      capture d
//     d     in   WIDTH  next value
//     q     out  WIDTH  registered value
// -----------------------------------------------------------------------------
module pipe_data_reg #(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             CLK,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Holding register: clear to RST_VAL, otherwise load or hold.
   always_ff @(posedge CLK) begin
      if (clr) begin
         q <= RST_VAL;
      end else if (load) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//   Pipeline stage register with valid/ready handshake on both sides, an
//   optional second (skid) entry and a synchronous flush that turns the stage
//   into a bubble. There is no combinational path from in_data/in_valid to
//   out_data/out_valid.
//   Parameters:
//     WIDTH   bits per entry
//     BUBBLE  value on out_data whenever no valid entry is held
//     SKID    1: two entries, in_ready from state only;
//             0: one entry, in_ready = ~out_valid | out_ready
//   Ports:
//     CLK        in   1      clock
//     CLR        in   1      synchronous active-high reset
//     flush      in   1      drop all held entries and the same-cycle input
//     bus        slave       in_valid/in_data/in_ready, out_valid/out_data/out_ready
//     occupancy  out  2      held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_skid_stage
   import pipe_skid_stage_pkg::*;
#(
   parameter int               WIDTH  = 32,
   parameter logic [WIDTH-1:0] BUBBLE = '0,
   parameter bit               SKID   = 1'b1
) (
   input  logic                    CLK,
   input  logic                    CLR,
   input  logic                    flush,
   pipe_skid_stage_if.slave        bus,
   output logic [1:0]              occupancy
);

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic             in_ready_s;
   logic             out_valid_s;
   logic             in_fire_s;
   logic             out_fire_s;
   logic             main_load_s;
   logic             main_clr_s;
   logic [WIDTH-1:0] main_d_s;
   logic [WIDTH-1:0] main_q_s;
   logic             skid_load_s;
   logic             skid_clr_s;
   logic [WIDTH-1:0] skid_q_s;

   assign out_valid_s = (state_r != ST_EMPTY);
   assign in_fire_s   = bus.in_valid & in_ready_s;
   assign out_fire_s  = out_valid_s & bus.out_ready;

   // With a skid entry the upstream ready depends only on the stage state,
   // which breaks the ready chain between stages. Without it, the stage can
   // accept only when it is empty or its head leaves this cycle.
   generate
      if (SKID) begin : g_skid
         assign in_ready_s = ~CLR & (state_r != ST_TWO);
      end else begin : g_single
         assign in_ready_s = ~CLR & (~out_valid_s | bus.out_ready);
      end
   endgenerate

   // Next-state and register-control decode. Reset and flush empty both
   // entries; leaving an entry empty always clears it so main shows BUBBLE.
   always_comb begin
      state_nxt_s = state_r;
      main_load_s = 1'b0;
      main_clr_s  = 1'b0;
      main_d_s    = bus.in_data;
      skid_load_s = 1'b0;
      skid_clr_s  = 1'b0;
      if (CLR || flush) begin
         state_nxt_s = ST_EMPTY;
         main_clr_s  = 1'b1;
         skid_clr_s  = 1'b1;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  state_nxt_s = ST_ONE;
                  main_load_s = 1'b1;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (in_fire_s && out_fire_s) begin
                  state_nxt_s = ST_ONE;
                  main_load_s = 1'b1;
               end else if (in_fire_s) begin
                  // Head is stalled: park the new entry behind it. In the
                  // single-entry build in_ready already implies out_fire.
                  if (SKID) begin
                     state_nxt_s = ST_TWO;
                     skid_load_s = 1'b1;
                  end else begin
                     state_nxt_s = ST_ONE;
                  end
               end else if (out_fire_s) begin
                  state_nxt_s = ST_EMPTY;
                  main_clr_s  = 1'b1;
               end else begin
                  state_nxt_s = ST_ONE;
               end
            end
            ST_TWO: begin
               if (out_fire_s) begin
                  state_nxt_s = ST_ONE;
                  main_load_s = 1'b1;
                  main_d_s    = skid_q_s;
                  skid_clr_s  = 1'b1;
               end else begin
                  state_nxt_s = ST_TWO;
               end
            end
            default: begin
               // Unreachable encoding: recover to a clean bubble.
               state_nxt_s = ST_EMPTY;
               main_clr_s  = 1'b1;
               skid_clr_s  = 1'b1;
            end
         endcase
      end
   end

   // Stage state register; flush is already folded into state_nxt_s.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_r <= ST_EMPTY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   pipe_data_reg #(
      .WIDTH   (WIDTH),
      .RST_VAL (BUBBLE)
   ) u_main (
      .CLK  (CLK),
      .clr  (main_clr_s),
      .load (main_load_s),
      .d    (main_d_s),
      .q    (main_q_s)
   );

   pipe_data_reg #(
      .WIDTH   (WIDTH),
      .RST_VAL (BUBBLE)
   ) u_skid (
      .CLK  (CLK),
      .clr  (skid_clr_s),
      .load (skid_load_s),
      .d    (bus.in_data),
      .q    (skid_q_s)
   );

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.out_data  = main_q_s;
   assign occupancy     = state_occupancy(state_r);

endmodule

// File: tb/tb_pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_stage
//   Two stages side by side: A (WIDTH=32, BUBBLE=0, SKID=1) and
//   B (WIDTH=8, BUBBLE=8'hFF, SKID=0). Each has a queue-based reference model
//   and a negedge monitor that pops and compares on every output transfer.
//   Inputs change only at posedge+1 and stay stable up to the next posedge.
// -----------------------------------------------------------------------------
module tb_pipe_skid_stage;

   logic       clk = 1'b0;
   logic       clr;
   logic       flush_a;
   logic       flush_b;
   logic [1:0] occ_a;
   logic [1:0] occ_b;
   logic       mon_en = 1'b0;
   logic       chk_c  = 1'b0;
   logic       seen_c = 1'b0;

   int checks   = 0;
   int failures = 0;

   logic [31:0] qa[$];
   logic [7:0]  qb[$];
   logic        a_exp_rdy;
   logic        a_exp_val;
   logic [31:0] a_head;
   logic        b_exp_rdy;
   logic        b_exp_val;
   logic [7:0]  b_head;

   pipe_skid_stage_if #(.WIDTH(32)) a_if ();
   pipe_skid_stage_if #(.WIDTH(8))  b_if ();

   pipe_skid_stage #(.WIDTH(32), .BUBBLE(32'h0000_0000), .SKID(1'b1)) u_a (
      .CLK       (clk),
      .CLR       (clr),
      .flush     (flush_a),
      .bus       (a_if),
      .occupancy (occ_a)
   );

   pipe_skid_stage #(.WIDTH(8), .BUBBLE(8'hFF), .SKID(1'b0)) u_b (
      .CLK       (clk),
      .CLR       (clr),
      .flush     (flush_b),
      .bus       (b_if),
      .occupancy (occ_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model A: up to two entries, ready whenever fewer than two are held.
   always @(negedge clk) begin
      if (mon_en) begin
         a_exp_rdy = !clr && (qa.size() < 2);
         a_exp_val = (qa.size() != 0);
         check("a_in_ready", {31'd0, a_if.in_ready}, {31'd0, a_exp_rdy});
         check("a_out_valid", {31'd0, a_if.out_valid}, {31'd0, a_exp_val});
         check("a_occupancy", {30'd0, occ_a}, 32'(qa.size()));
         if (chk_c && a_if.out_valid && a_if.out_data == 32'h0000_000C) seen_c = 1'b1;
         if (!a_exp_val) begin
            check("a_bubble", a_if.out_data, 32'h0000_0000);
         end else if (a_if.out_ready && !clr && !flush_a) begin
            a_head = qa.pop_front();
            check("a_out_fire_data", a_if.out_data, a_head);
         end else begin
            check("a_head_data", a_if.out_data, qa[0]);
         end
         if (clr || flush_a) qa.delete();
         else if (a_if.in_valid && a_exp_rdy) qa.push_back(a_if.in_data);
      end
   end

   // Model B: one entry, ready when empty or when the head leaves now.
   always @(negedge clk) begin
      if (mon_en) begin
         b_exp_rdy = !clr && (qb.size() == 0 || b_if.out_ready);
         b_exp_val = (qb.size() != 0);
         check("b_in_ready", {31'd0, b_if.in_ready}, {31'd0, b_exp_rdy});
         check("b_out_valid", {31'd0, b_if.out_valid}, {31'd0, b_exp_val});
         check("b_occupancy", {30'd0, occ_b}, 32'(qb.size()));
         if (!b_exp_val) begin
            check("b_bubble", {24'd0, b_if.out_data}, 32'h0000_00FF);
         end else if (b_if.out_ready && !clr && !flush_b) begin
            b_head = qb.pop_front();
            check("b_out_fire_data", {24'd0, b_if.out_data}, {24'd0, b_head});
         end else begin
            check("b_head_data", {24'd0, b_if.out_data}, {24'd0, qb[0]});
         end
         if (clr || flush_b) qb.delete();
         else if (b_if.in_valid && b_exp_rdy) qb.push_back(b_if.in_data);
      end
   end

   initial begin
      clr = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
      a_if.in_valid = 1'b0; a_if.in_data = 32'd0; a_if.out_ready = 1'b0;
      b_if.in_valid = 1'b0; b_if.in_data = 8'd0;  b_if.out_ready = 1'b0;

      // Reset held for two edges; ready low during, high after.
      step();
      mon_en = 1'b1;
      @(negedge clk);
      check("rst_a_in_ready_low", {31'd0, a_if.in_ready}, 32'd0);
      check("rst_b_in_ready_low", {31'd0, b_if.in_ready}, 32'd0);
      step();
      clr = 1'b0;
      @(negedge clk);
      check("rst_a_out_valid", {31'd0, a_if.out_valid}, 32'd0);
      check("rst_a_out_data", a_if.out_data, 32'd0);
      check("rst_a_occupancy", {30'd0, occ_a}, 32'd0);
      check("rst_a_in_ready_high", {31'd0, a_if.in_ready}, 32'd1);
      check("rst_b_out_data", {24'd0, b_if.out_data}, 32'h0000_00FF);
      step();

      // Streaming 1..4 with the consumer always ready.
      a_if.out_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         a_if.in_valid = (k <= 4);
         a_if.in_data  = 32'(k);
         @(negedge clk);
         if (k >= 2) begin
            check("stream_data", a_if.out_data, 32'(k - 1));
            check("stream_occ", {30'd0, occ_a}, 32'd1);
            check("stream_ready", {31'd0, a_if.in_ready}, 32'd1);
         end
         step();
      end
      a_if.in_valid = 1'b0;
      step();

      // Backpressure fills both entries; drain keeps order.
      a_if.out_ready = 1'b0;
      a_if.in_valid = 1'b1; a_if.in_data = 32'h0000_000A; step();
      a_if.in_data = 32'h0000_000B; step();
      a_if.in_data = 32'h0000_000D;
      @(negedge clk);
      check("bp_occ_two", {30'd0, occ_a}, 32'd2);
      check("bp_ready_low", {31'd0, a_if.in_ready}, 32'd0);
      check("bp_head_held", a_if.out_data, 32'h0000_000A);
      step();
      a_if.in_valid = 1'b0; a_if.out_ready = 1'b1;
      @(negedge clk);
      check("drain_first", a_if.out_data, 32'h0000_000A);
      step();
      @(negedge clk);
      check("drain_second", a_if.out_data, 32'h0000_000B);
      check("drain_occ_one", {30'd0, occ_a}, 32'd1);
      check("drain_ready", {31'd0, a_if.in_ready}, 32'd1);
      step();
      @(negedge clk);
      check("drain_empty", {30'd0, occ_a}, 32'd0);
      step();

      // Flush with two held entries and a same-cycle input of 0xC.
      chk_c = 1'b1;
      a_if.out_ready = 1'b0;
      a_if.in_valid = 1'b1; a_if.in_data = 32'h0000_0011; step();
      a_if.in_data = 32'h0000_0012; step();
      a_if.in_data = 32'h0000_000C; flush_a = 1'b1; step();
      flush_a = 1'b0; a_if.in_valid = 1'b0; a_if.out_ready = 1'b1;
      @(negedge clk);
      check("flush_valid", {31'd0, a_if.out_valid}, 32'd0);
      check("flush_data", a_if.out_data, 32'd0);
      check("flush_occ", {30'd0, occ_a}, 32'd0);
      step(); step();
      chk_c = 1'b0;
      check("flush_c_never_seen", {31'd0, seen_c}, 32'd0);

      // Simultaneous in/out transfer in ONE.
      a_if.out_ready = 1'b0;
      a_if.in_valid = 1'b1; a_if.in_data = 32'h0000_0005; step();
      a_if.in_data = 32'h0000_0006; a_if.out_ready = 1'b1; step();
      a_if.in_valid = 1'b0; a_if.out_ready = 1'b0;
      @(negedge clk);
      check("swap_data", a_if.out_data, 32'h0000_0006);
      check("swap_occ", {30'd0, occ_a}, 32'd1);
      step();
      a_if.out_ready = 1'b1; step(); step();

      // Single-entry stage: in_ready follows out_ready combinationally.
      b_if.in_valid = 1'b1; b_if.in_data = 8'h3C; b_if.out_ready = 1'b0; step();
      b_if.in_data = 8'h77;
      @(negedge clk);
      check("b_ready_blocked", {31'd0, b_if.in_ready}, 32'd0);
      check("b_held", {24'd0, b_if.out_data}, 32'h0000_003C);
      step();
      b_if.in_valid = 1'b0; b_if.out_ready = 1'b1;
      @(negedge clk);
      check("b_ready_same_cycle", {31'd0, b_if.in_ready}, 32'd1);
      step();
      @(negedge clk);
      check("b_drained_bubble", {24'd0, b_if.out_data}, 32'h0000_00FF);
      step();

      // Randomized traffic with occasional flush and reset on both stages.
      for (int n = 0; n < 600; n++) begin
         clr     = ($urandom_range(0, 63) == 0);
         flush_a = ($urandom_range(0, 31) == 0);
         flush_b = ($urandom_range(0, 31) == 0);
         a_if.in_valid  = ($urandom_range(0, 9) < 6);
         a_if.in_data   = $urandom();
         a_if.out_ready = ($urandom_range(0, 9) < 5);
         b_if.in_valid  = ($urandom_range(0, 9) < 6);
         b_if.in_data   = 8'($urandom());
         b_if.out_ready = ($urandom_range(0, 9) < 5);
         step();
      end
      clr = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
      a_if.in_valid = 1'b0; a_if.out_ready = 1'b1;
      b_if.in_valid = 1'b0; b_if.out_ready = 1'b1;
      for (int n = 0; n < 4; n++) step();
      @(negedge clk);
      check("end_a_empty", {30'd0, occ_a}, 32'd0);
      check("end_b_empty", {30'd0, occ_b}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
